demux_router: RTL
=================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output channel FIFO; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  payload to route.
REQ-006 in_sel  input  2  destination channel 0..3.
REQ-007 in_valid  input  1  in_data/in_sel valid.
REQ-008 in_ready  output  1  router accepts the offered word this cycle.
REQ-009 out_data  output  4*WIDTH  channel i head at bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  4  bit i: channel i head valid.
REQ-011 out_ready  input  4  bit i: consumer i takes head.
REQ-012 out_count  output  4*($clog2(DEPTH)+1)  per-channel occupancy, same slicing as out_data.

Function
REQ-013 in_ready SHALL equal NOT full[in_sel], and SHALL be 0 while rst=1.
REQ-014 Push SHALL occur only on in_valid & in_ready; word is written to FIFO in_sel at that edge.
REQ-015 Push latency SHALL be one cycle: a word pushed into an empty channel asserts out_valid[i] on the following cycle; no combinational bypass.
REQ-016 out_valid[i] SHALL equal (count[i] != 0); out_data slice i SHALL be the FIFO i head, held stable while out_valid[i] & ~out_ready[i].
REQ-017 Pop on channel i SHALL occur only on out_valid[i] & out_ready[i]; out_ready[i] with out_valid[i]=0 SHALL have no effect.
REQ-018 Simultaneous push and pop on the same non-full channel SHALL leave count[i] unchanged and preserve FIFO order.
REQ-019 A full channel SHALL NOT accept a push even if popped the same cycle (in_ready depends on full only).
REQ-020 Pops on all four channels and one push SHALL be serviced in the same cycle independently.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-022 Blocked channel SHALL NOT block others: when in_sel changes to a non-full channel, in_ready reflects the new channel in the same cycle.
REQ-023 Order SHALL be preserved per channel; no ordering guarantee across channels.
REQ-024 in_sel/in_data SHALL be sampled only at the push edge; changes while in_ready=0 SHALL NOT corrupt state.

Reset
REQ-025 On rst=1 at a clock edge all pointers and counts SHALL clear: out_valid=4'b0000, out_count=0.
REQ-026 Reset mid-operation SHALL discard all buffered words; no push or pop SHALL take effect on a reset edge.
REQ-027 out_data after reset SHALL be don't-care while out_valid=0; storage arrays need no reset.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-029 Package demux_pkg SHALL hold NUM_CH=4, SEL_W=2 and a localparam helper for count width.
REQ-030 One sub-module chan_fifo (WIDTH, DEPTH; push, pop, data, full, empty, count) SHALL be instantiated NUM_CH times by generate.
REQ-031 Top level SHALL contain only the in_sel decode, in_ready select, and output packing.

Verification
REQ-032 Reset, then in_data=8'hA5,in_sel=2'b10,in_valid=1 for one cycle -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5, out_count ch2=1.
REQ-033 out_ready=0; push 8'h11,8'h22 to ch1 -> out_count ch1=2, in_ready=0 with in_sel=1, in_ready=1 with in_sel=3.
REQ-034 Ch0 holds 1 word; push 8'h33 and pop same cycle -> count stays 1, next head 8'h33, out_valid[0]=1.
REQ-035 Full ch3, out_ready[3]=1 and push to ch3 same cycle -> push refused, count 2->1; push succeeds next cycle.
REQ-036 Push 6 words 8'h01..8'h06 to ch0 with continuous pop -> outputs 01..06 in order across pointer wrap.
REQ-037 Fill ch0 and ch2, assert rst one cycle mid-stream -> out_valid=0, all counts 0, in_ready=1 next cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demux router and its per-channel FIFOs.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Occupancy counters must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux_router_chan_fifo.sv
// Single-clock FIFO for one output channel: registered head, no bypass path.
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_en) - CW'(pop_en);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; its contents are ignored while count is zero.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/demux_router.sv
// Routes one input stream to four independently buffered output channels.
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_CH*WIDTH-1:0]          out_data,
    output logic [NUM_CH-1:0]                out_valid,
    input  logic [NUM_CH-1:0]                out_ready,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0]   out_count
);

    localparam int CW = cnt_w(DEPTH);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push_ch;
    logic [NUM_CH-1:0] pop_ch;

    // Readiness follows only the addressed channel, so a full channel never stalls others.
    assign in_ready  = ~rst & ~full[in_sel];
    assign pop_ch    = out_ready & ~empty;
    assign out_valid = ~empty;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push_ch[i] = in_valid & in_ready & (in_sel == SEL_W'(i));

        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push_ch[i]),
            .pop     (pop_ch[i]),
            .wr_data (in_data),
            .rd_data (out_data[i*WIDTH +: WIDTH]),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (out_count[i*CW +: CW])
        );
    end

endmodule
